match_event_logger: RTL
=======================

// Module: match_event_logger
// PURPOSE
//  Downstream consumer of the Moore sequence detector's one-bit match output.
//  - Counts detections and timestamps each one into a small first-word-fall-through (FWFT) FIFO.
//  - Raises a sticky alarm when a programmable count is reached.
//  - Lets a host read match history through a valid/ready pop interface.
// PARAMETERS
//  CNT_W       16  width of match counter and threshold
//  TS_W        16  width of free-running timestamp and FIFO entries
//  FIFO_DEPTH  4   timestamp FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  match_in   in   1      detector output; each high cycle = one match
//  clr        in   1      synchronous clear of counts/FIFO/flags (not timestamp)
//  thresh     in   CNT_W  alarm threshold; 0 disables alarm
//  match_cnt  out  CNT_W  registered match count, saturating
//  cnt_sat    out  1      sticky: match_cnt reached all-ones
//  alarm      out  1      sticky: match_cnt >= thresh (thresh != 0)
//  ts_valid   out  1      FIFO non-empty
//  ts_data    out  TS_W   FIFO head timestamp (FWFT)
//  ts_ready   in   1      host accepts head when ts_valid=1
//  fifo_full  out  1      FIFO holds FIFO_DEPTH entries
//  overflow   out  1      sticky: a match timestamp was dropped
// BEHAVIOUR
//  Reset: rst=1 at an edge zeroes ts counter, match_cnt, cnt_sat, alarm and overflow; empties FIFO.
//    After that edge: ts_valid=0, fifo_full=0, ts_data=0. rst overrides all other inputs.
//  Timestamp: ts increments by 1 every cycle, wraps 2^TS_W-1 -> 0. clr does not affect it.
//  Counting: at an edge with match_in=1, match_cnt <= match_cnt+1. Latency is 1 cycle.
//    At all-ones, match_cnt holds and cnt_sat <= 1.
//    Overlapping detections give back-to-back high cycles; each one counts.
//  Alarm: alarm <= 1 at the edge where the updated match_cnt >= thresh and thresh != 0.
//    Stays 1 until clr or rst, even if thresh later changes.
//  Push: at an edge with match_in=1, the pre-increment ts value is written to the FIFO tail.
//  Pop: at an edge with ts_valid & ts_ready, the head is removed.
//    ts_data shows the next entry in the following cycle.
//  Full: push with FIFO full and no pop in the same cycle -> entry dropped, overflow <= 1.
//    match_cnt still increments.
//  Full + push + pop in the same cycle: both succeed, occupancy unchanged, no overflow.
//  Empty: ts_ready with ts_valid=0 is ignored. Push into empty FIFO -> ts_valid=1 next cycle.
//  Pointers: read/write pointers wrap modulo FIFO_DEPTH.
//    One extra wrap bit distinguishes full from empty.
//  Clear: clr=1 at an edge acts like rst on everything except ts.
//    It beats a coincident match_in (match not counted, not pushed) and a coincident pop.
//  Reset or clear mid-stream: pending FIFO contents are discarded with no partial pop.
//  ts_data when ts_valid=0 is don't-care; the bench must not check it.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> match_cnt=0, alarm=0, ts_valid=0, overflow=0, cnt_sat=0.
//  2 Count+stamp: match_in high at ts=5, 6 and 10 -> match_cnt=3.
//    Popping with ts_ready=1 yields 5, 6, 10, then ts_valid=0.
//  3 Overflow: DEPTH=4, ts_ready=0, 6 matches -> fifo_full=1, overflow=1, match_cnt=6.
//    Pops return the first 4 stamps only.
//  4 Full push+pop: FIFO full, match_in=1 and ts_ready=1 in one cycle -> overflow stays 0.
//    fifo_full stays 1 and the new stamp comes out last.
//  5 Alarm: thresh=3; third match -> alarm=1 one cycle later. thresh=0 run of 10 matches -> alarm=0.
//  6 Saturation/clear: CNT_W=4, 17 matches -> match_cnt=15, cnt_sat=1.
//    clr with match_in=1 -> match_cnt=0 and FIFO empty next cycle; ts keeps counting.

Source files
------------

// File: rtl/match_event_logger.sv
// Counts sequence-detector matches, timestamps each one into a small FWFT FIFO,
// and raises sticky alarm / saturation / overflow flags for a host reading match history.
module match_event_logger #(
    parameter int CNT_W      = 16,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             match_in,
    input  logic             clr,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             alarm,
    output logic             ts_valid,
    output logic [TS_W-1:0]  ts_data,
    input  logic             ts_ready,
    output logic             fifo_full,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             alarm_q, alarm_d;
    logic             ovf_q, ovf_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [TS_W-1:0]  mem_q [FIFO_DEPTH];
    logic [TS_W-1:0]  mem_d [FIFO_DEPTH];

    logic empty, full, push, pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push     = match_in && !clr;
        pop      = !empty && ts_ready && !clr;

        ts_d     = ts_q + 1'b1;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        alarm_d  = alarm_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;

        if (clr) begin
            cnt_d    = '0;
            sat_d    = 1'b0;
            alarm_d  = 1'b0;
            ovf_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == {CNT_W{1'b1}}) begin
                sat_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
            if (push) begin
                if (!full || pop) begin
                    mem_d[wr_ptr_q[AW-1:0]] = ts_q;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if ((thresh != '0) && (cnt_d >= thresh)) begin
                alarm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            alarm_q  <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            ts_q     <= ts_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            alarm_q  <= alarm_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: its contents are only visible while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
    assign alarm     = alarm_q;
    assign overflow  = ovf_q;
    assign ts_valid  = !empty;
    assign fifo_full = full;
    assign ts_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
